// File: rtl/weighted_sched.sv
// Weighted scheduler: collects one AUL result per channel, then issues the four operands
// plus the current weight to a fixed-latency datapath and buffers its results in issue order.
module weighted_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int DP_LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        cfg_we,
  input  logic [15:0] cfg_mu,
  input  logic [3:0]  ch_valid,
  output logic [3:0]  ch_ready,
  input  logic [15:0] ch_data0,
  input  logic [15:0] ch_data1,
  input  logic [15:0] ch_data2,
  input  logic [15:0] ch_data3,
  output logic        dp_enable,
  output logic [15:0] dp_data1,
  output logic [15:0] dp_data2,
  output logic [15:0] dp_data3,
  output logic [15:0] dp_data4,
  output logic [15:0] dp_mu,
  input  logic        dp_valid,
  input  logic [15:0] dp_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(FIFO_DEPTH + 1);
  localparam int MAX_INFL = (DP_LATENCY < FIFO_DEPTH) ? DP_LATENCY : FIFO_DEPTH;
  localparam int IW       = $clog2(MAX_INFL + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_STALL  = 2'd2
  } state_e;

  logic              rst_sync_q;
  logic [3:0]        full_q;
  logic [15:0]       slot_q [4];
  logic [15:0]       ch_data [4];
  logic [15:0]       mu_q;
  logic [IW-1:0]     inflight_q;
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [15:0]       mem_q [FIFO_DEPTH];
  logic              err_q;
  state_e            state_q;
  state_e            state_d;
  logic              all_full;
  logic              credit_ok;
  logic              issue;
  logic              push;
  logic              pop;
  logic [3:0]        accept;

  // Reset asserts immediately but releases on a clock edge; ready rises on the first
  // edge after release so the first active edge sees clean state everywhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 1'b0;
    else      rst_sync_q <= 1'b1;
  end

  assign ch_data[0] = ch_data0;
  assign ch_data[1] = ch_data1;
  assign ch_data[2] = ch_data2;
  assign ch_data[3] = ch_data3;

  // Handshakes: a beat transfers on the rising edge where valid and ready are both high;
  // ready never depends on valid, and res_valid stays high until the head is popped.
  assign ch_ready  = ~full_q & {4{rst_sync_q}};
  assign accept    = ch_valid & ch_ready;
  assign all_full  = &full_q;
  assign credit_ok = (int'(inflight_q) + int'(count_q)) < FIFO_DEPTH;
  assign issue     = run & all_full & credit_ok;
  assign push      = dp_valid & (inflight_q != '0);
  assign pop       = res_valid & res_ready;

  assign dp_enable = issue;
  assign dp_data1  = issue ? slot_q[0] : '0;
  assign dp_data2  = issue ? slot_q[1] : '0;
  assign dp_data3  = issue ? slot_q[2] : '0;
  assign dp_data4  = issue ? slot_q[3] : '0;
  assign dp_mu     = issue ? mu_q : '0;

  assign res_valid = (count_q != '0);
  assign res_data  = res_valid ? mem_q[rd_q] : '0;
  assign busy      = (|full_q) | (inflight_q != '0) | (count_q != '0);
  assign err       = err_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      full_q <= '0;
      for (int k = 0; k < 4; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (issue) begin
          full_q[k] <= 1'b0;
        end else if (accept[k]) begin
          full_q[k] <= 1'b1;
          slot_q[k] <= ch_data[k];
        end
      end
    end
  end

  // The issue stage reads mu_q, so a same-cycle write only affects later issues.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      mu_q       <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (cfg_we) mu_q <= cfg_mu;
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + IW'(1);
        2'b01:   inflight_q <= inflight_q - IW'(1);
        default: inflight_q <= inflight_q;
      endcase
      if (dp_valid && (inflight_q == '0)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= dp_result;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_GATHER;
        S_GATHER: if (all_full && !credit_ok) state_d = S_STALL;
        S_STALL:  if (credit_ok) state_d = S_GATHER;
        default:  state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weighted_sched.sv
// Bench for weighted_sched: a 5-cycle Horner weighted-sum datapath model feeds results back,
// and an in-order scoreboard checks every popped result.
module tb_weighted_sched;

  localparam int FIFO_DEPTH = 4;
  localparam int DP_LATENCY = 5;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        cfg_we;
  logic [15:0] cfg_mu;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_ready;
  logic [15:0] ch_data0, ch_data1, ch_data2, ch_data3;
  logic        dp_enable;
  logic [15:0] dp_data1, dp_data2, dp_data3, dp_data4, dp_mu;
  logic        dp_valid;
  logic [15:0] dp_result;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int issue_cnt = 0;
  logic [15:0] exp_q[$];

  logic [DP_LATENCY-1:0] vld_pipe;
  logic [15:0]           res_pipe [DP_LATENCY];
  logic                  spur_valid;
  logic [15:0]           spur_data;

  weighted_sched #(.FIFO_DEPTH(FIFO_DEPTH), .DP_LATENCY(DP_LATENCY)) dut (
    .clk(clk), .rst(rst), .run(run), .cfg_we(cfg_we), .cfg_mu(cfg_mu),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_data0(ch_data0), .ch_data1(ch_data1), .ch_data2(ch_data2), .ch_data3(ch_data3),
    .dp_enable(dp_enable), .dp_data1(dp_data1), .dp_data2(dp_data2), .dp_data3(dp_data3),
    .dp_data4(dp_data4), .dp_mu(dp_mu), .dp_valid(dp_valid), .dp_result(dp_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // d1 + mu*(d2 + mu*(d3 + mu*d4)) in Q1.14
  function automatic logic [15:0] horner(input logic [15:0] d1, input logic [15:0] d2,
                                         input logic [15:0] d3, input logic [15:0] d4,
                                         input logic [15:0] mu);
    int acc;
    acc = int'($signed(d4));
    acc = int'($signed(d3)) + ((acc * int'($signed(mu))) >>> 14);
    acc = int'($signed(d2)) + ((acc * int'($signed(mu))) >>> 14);
    acc = int'($signed(d1)) + ((acc * int'($signed(mu))) >>> 14);
    return acc[15:0];
  endfunction

  // ---------------- datapath model ----------------
  assign dp_valid  = vld_pipe[DP_LATENCY-1] | spur_valid;
  assign dp_result = spur_valid ? spur_data : res_pipe[DP_LATENCY-1];

  always @(posedge clk) begin
    vld_pipe    <= {vld_pipe[DP_LATENCY-2:0], dp_enable};
    res_pipe[0] <= horner(dp_data1, dp_data2, dp_data3, dp_data4, dp_mu);
    for (int i = 1; i < DP_LATENCY; i++) res_pipe[i] <= res_pipe[i-1];
    if (dp_enable === 1'b1) begin
      exp_q.push_back(horner(dp_data1, dp_data2, dp_data3, dp_data4, dp_mu));
      issue_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got %h with no result expected", res_data);
      end else begin
        logic [15:0] exp_v;
        exp_v = exp_q.pop_front();
        if (res_data !== exp_v) begin
          n_fail++;
          $display("FAIL sb_order: got %h exp %h", res_data, exp_v);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_slots(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
    int t = 0;
    while (ch_ready !== 4'hF && t < 20) begin tick(); t++; end
    n_checks++;
    if (ch_ready !== 4'hF) begin n_fail++; $display("FAIL load_ready: got %h exp f", ch_ready); end
    ch_data0 = d0; ch_data1 = d1; ch_data2 = d2; ch_data3 = d3;
    ch_valid = 4'hF;
    tick();
    ch_valid = 4'h0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int t = 0;
    while (busy !== 1'b0 && t < max_cyc) begin tick(); t++; end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: busy=%b exp 0 after %0d cycles", busy, t); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (ch_ready !== 4'h0) begin n_fail++; $display("FAIL rst_ready: got %h exp 0", ch_ready); end
    n_checks++; if (dp_enable !== 1'b0) begin n_fail++; $display("FAIL rst_dp_enable: got %b exp 0", dp_enable); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b exp 0", res_valid); end
    n_checks++; if (res_data !== 16'h0) begin n_fail++; $display("FAIL rst_res_data: got %h exp 0", res_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", err); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    n_checks++; if (dp_mu !== 16'h0 || dp_data1 !== 16'h0) begin n_fail++; $display("FAIL rst_dp_ops: got mu %h d1 %h exp 0", dp_mu, dp_data1); end
    rst = 1'b1;
    #1;
    n_checks++; if (ch_ready !== 4'h0) begin n_fail++; $display("FAIL rel_ready_early: got %h exp 0", ch_ready); end
    tick();
    n_checks++; if (ch_ready !== 4'hF) begin n_fail++; $display("FAIL rel_ready: got %h exp f", ch_ready); end
  endtask

  task automatic test_basic();
    int base;
    cfg_mu = 16'h2000; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    run = 1'b1; res_ready = 1'b1;
    base = issue_cnt;
    n_checks++; if (dp_enable !== 1'b0) begin n_fail++; $display("FAIL basic_no_issue: got %b exp 0", dp_enable); end
    load_slots(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    n_checks++; if (dp_enable !== 1'b1) begin n_fail++; $display("FAIL basic_issue: got %b exp 1", dp_enable); end
    n_checks++; if (dp_data1 !== 16'h4000 || dp_data4 !== 16'h4000) begin n_fail++; $display("FAIL basic_ops: got %h %h exp 4000", dp_data1, dp_data4); end
    n_checks++; if (dp_mu !== 16'h2000) begin n_fail++; $display("FAIL basic_mu: got %h exp 2000", dp_mu); end
    repeat (5) tick();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_res: got %b exp 0", res_valid); end
    tick();
    n_checks++; if (res_valid !== 1'b1 || res_data !== 16'h7800) begin n_fail++; $display("FAIL basic_result: got v=%b %h exp v=1 7800", res_valid, res_data); end
    tick();
    n_checks++; if (issue_cnt - base != 1) begin n_fail++; $display("FAIL basic_issue_cnt: got %0d exp 1", issue_cnt - base); end
    n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got busy %b res_valid %b exp 0 0", busy, res_valid); end
  endtask

  task automatic test_skew();
    int base;
    base = issue_cnt;
    ch_data0 = 16'h0400; ch_data1 = 16'h0800; ch_data2 = 16'h0C00; ch_data3 = 16'h1000;
    for (int cyc = 0; cyc < 8; cyc++) begin
      ch_valid = (cyc == 0) ? 4'h1 : (cyc == 2) ? 4'h2 : (cyc == 4) ? 4'h4 : (cyc == 7) ? 4'h8 : 4'h0;
      n_checks++; if (dp_enable !== 1'b0) begin n_fail++; $display("FAIL skew_early cyc %0d: got %b exp 0", cyc, dp_enable); end
      tick();
    end
    ch_valid = 4'h0;
    n_checks++; if (dp_enable !== 1'b1) begin n_fail++; $display("FAIL skew_issue: got %b exp 1", dp_enable); end
    tick();
    n_checks++; if (dp_enable !== 1'b0) begin n_fail++; $display("FAIL skew_single: got %b exp 0", dp_enable); end
    repeat (5) tick();
    n_checks++; if (res_valid !== 1'b1 || res_data !== 16'h0D00) begin n_fail++; $display("FAIL skew_result: got v=%b %h exp v=1 0d00", res_valid, res_data); end
    n_checks++; if (issue_cnt - base != 1) begin n_fail++; $display("FAIL skew_issue_cnt: got %0d exp 1", issue_cnt - base); end
    wait_idle(20);
  endtask

  task automatic test_backpressure();
    int base;
    res_ready = 1'b0;
    base = issue_cnt;
    ch_data1 = 16'h0200; ch_data2 = 16'h0200; ch_data3 = 16'h0200;
    ch_valid = 4'hF;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ch_data0 = 16'h0100 + cyc[15:0];
      tick();
    end
    n_checks++; if (issue_cnt - base != FIFO_DEPTH) begin n_fail++; $display("FAIL bp_issue_cnt: got %0d exp %0d", issue_cnt - base, FIFO_DEPTH); end
    n_checks++; if (dbg_state !== ST_STALL) begin n_fail++; $display("FAIL bp_state: got %0d exp 2", dbg_state); end
    n_checks++; if (ch_ready !== 4'h0 || res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got ready %h res_valid %b exp 0 1", ch_ready, res_valid); end
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ch_data0 = 16'h0300 + cyc[15:0];
      tick();
    end
    n_checks++; if (issue_cnt - base <= FIFO_DEPTH) begin n_fail++; $display("FAIL bp_resume: got %0d issues exp more than %0d", issue_cnt - base, FIFO_DEPTH); end
    ch_valid = 4'h0;
    wait_idle(60);
  endtask

  task automatic test_mu_update();
    load_slots(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    n_checks++; if (dp_enable !== 1'b1) begin n_fail++; $display("FAIL mu_issue1: got %b exp 1", dp_enable); end
    cfg_mu = 16'h1000; cfg_we = 1'b1;
    #1;
    n_checks++; if (dp_mu !== 16'h2000) begin n_fail++; $display("FAIL mu_old: got %h exp 2000", dp_mu); end
    tick();
    cfg_we = 1'b0;
    load_slots(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    n_checks++; if (dp_enable !== 1'b1 || dp_mu !== 16'h1000) begin n_fail++; $display("FAIL mu_new: got en %b mu %h exp 1 1000", dp_enable, dp_mu); end
    wait_idle(30);
  endtask

  task automatic test_spurious();
    spur_data = 16'h1234; spur_valid = 1'b1;
    tick();
    spur_valid = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_err: got %b exp 1", err); end
    n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL spur_no_push: got res_valid %b busy %b exp 0 0", res_valid, busy); end
    repeat (10) tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got %b exp 1", err); end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    int t = 0;
    res_ready = 1'b0;
    ch_data0 = 16'h4000; ch_data1 = 16'h4000; ch_data2 = 16'h4000; ch_data3 = 16'h4000;
    ch_valid = 4'hF;
    while (seen < 3 && t < 30) begin
      tick(); t++;
      if (dp_enable === 1'b1) seen++;
    end
    ch_valid = 4'h0;
    n_checks++; if (seen != 3) begin n_fail++; $display("FAIL mid_issues: got %0d exp 3", seen); end
    repeat (2) tick();
    n_checks++; if (res_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_buffered: got res_valid %b busy %b exp 1 1", res_valid, busy); end
    rst = 1'b0;
    #1;
    exp_q.delete();
    n_checks++; if (res_valid !== 1'b0 || res_data !== 16'h0) begin n_fail++; $display("FAIL mid_rst_res: got v=%b %h exp v=0 0000", res_valid, res_data); end
    n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: got busy %b err %b exp 0 0", busy, err); end
    n_checks++; if (ch_ready !== 4'h0 || dp_enable !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hs: got ready %h en %b exp 0 0", ch_ready, dp_enable); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL mid_rst_state: got %0d exp 0", dbg_state); end
    repeat (2) tick();
    rst = 1'b1;
    #1;
    n_checks++; if (ch_ready !== 4'h0) begin n_fail++; $display("FAIL mid_rel_early: got %h exp 0", ch_ready); end
    tick();
    n_checks++; if (ch_ready !== 4'hF || err !== 1'b0) begin n_fail++; $display("FAIL mid_rel: got ready %h err %b exp f 0", ch_ready, err); end
    tick();
    n_checks++; if (err !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_late_valid: got err %b res_valid %b exp 1 0", err, res_valid); end
    res_ready = 1'b1;
    load_slots(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    n_checks++; if (dp_enable !== 1'b1 || dp_mu !== 16'h0) begin n_fail++; $display("FAIL mid_mu_cleared: got en %b mu %h exp 1 0000", dp_enable, dp_mu); end
    repeat (6) tick();
    n_checks++; if (res_valid !== 1'b1 || res_data !== 16'h0100) begin n_fail++; $display("FAIL mid_post_result: got v=%b %h exp v=1 0100", res_valid, res_data); end
    wait_idle(20);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0; run = 1'b0; cfg_we = 1'b0; cfg_mu = 16'h0;
    ch_valid = 4'h0; ch_data0 = 16'h0; ch_data1 = 16'h0; ch_data2 = 16'h0; ch_data3 = 16'h0;
    res_ready = 1'b0; spur_valid = 1'b0; spur_data = 16'h0;
    vld_pipe = '0;
    for (int i = 0; i < DP_LATENCY; i++) res_pipe[i] = 16'h0;

    test_reset();
    test_basic();
    test_skew();
    test_backpressure();
    test_mu_update();
    test_spurious();
    test_reset_midflight();

    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending exp 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/weighted_sched.md
WEIGHTED_SCHED -- requirements
Module: weighted_sched

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, result buffer entries (power of two, >=2).
REQ-002 Parameter: DP_LATENCY, 5, cycles from dp_enable to dp_valid in the weighted-sum datapath.
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: run  in  1  level; 1 = issuing allowed.
REQ-006 Port: cfg_we  in  1  mu write strobe.
REQ-007 Port: cfg_mu  in  16  signed Q1.14 weight.
REQ-008 Port: ch_valid[3:0] / ch_ready[3:0]  in/out  4/4  per-channel AUL result handshake (channel k maps to datapath data(k+1)).
REQ-009 Port: ch_data0..ch_data3  in  16 each  signed AUL results.
REQ-010 Port: dp_enable  out  1  single-cycle issue strobe to datapath.
REQ-011 Port: dp_data1..dp_data4, dp_mu  out  16 each  operands, valid only while dp_enable=1.
REQ-012 Port: dp_valid / dp_result  in  1/16  datapath completion and signed result.
REQ-013 Port: res_valid / res_ready / res_data  out/in/out  1/1/16  result stream.
REQ-014 Port: busy  out  1  any slot full, any in-flight, or buffer non-empty.
REQ-015 Port: err  out  1  sticky unexpected-completion flag.

Function
REQ-016 Each channel k SHALL have one holding slot; ch_ready[k] = ~full[k]; accept on ch_valid[k]&ch_ready[k] sets full[k] and captures data.
REQ-017 mu_reg SHALL load cfg_mu on cfg_we at any time; issue SHALL use mu_reg value before a same-cycle write.
REQ-018 credits SHALL equal FIFO_DEPTH - inflight - fifo_count; issue only when credits>0, so buffer can never overflow.
REQ-019 FSM states: IDLE (run=0), GATHER (waiting for all four slots), STALL (all full, credits=0); IDLE->GATHER when run=1; GATHER->STALL when all full and credits=0; STALL->GATHER when credit returns; any state->IDLE when run=0 (slots retained).
REQ-020 Issue condition: run=1, all four full, credits>0; that cycle dp_enable=1 with slot data and mu_reg, and all full flags clear at the next edge.
REQ-021 Slots SHALL NOT accept new data in the issue cycle (ready derived from registered full flags); earliest refill is next cycle, giving max one issue per 2 cycles.
REQ-022 dp_enable SHALL be combinationally free of ch_valid (driven from registered state only).
REQ-023 inflight SHALL increment on issue, decrement on dp_valid; simultaneous events leave it unchanged.
REQ-024 dp_valid SHALL push dp_result into the FIFO; res_valid = FIFO non-empty; pop on res_valid&res_ready; push and pop in the same cycle on non-empty FIFO keep count.
REQ-025 Results SHALL exit in issue order with no loss or duplication.
REQ-026 dp_valid with inflight=0 SHALL set err (held until reset) and SHALL NOT push.
REQ-027 run deassert SHALL NOT cancel in-flight operations; their results still enter the FIFO.

Reset
REQ-028 On rst low, immediately: full flags=0, ch_ready=0 while asserted, mu_reg=0, inflight=0, FIFO empty, state=IDLE, dp_enable=0, dp_data*/dp_mu=0, res_valid=0, res_data=0, busy=0, err=0.
REQ-029 Reset assertion mid-operation SHALL discard slots, in-flight tracking and buffered results; dp_valid pulses while rst low are ignored.
REQ-030 Deassertion SHALL be synchronised so first active edge is clean; ch_ready=4'hF one cycle after release.

Verification
REQ-031 mu=0x2000, all channels 0x4000, run=1, datapath model latency 5 -> one dp_enable, res_data=0x7800 six cycles later.
REQ-032 Channels arrive skewed (ch0 cycle 0, ch3 cycle 7) -> dp_enable exactly one cycle after ch3 accept, none earlier.
REQ-033 res_ready=0, continuous input -> exactly FIFO_DEPTH issues, FSM in STALL, no overflow; raise res_ready -> results drain in order, issuing resumes.
REQ-034 cfg_we with new mu in issue cycle -> that issue uses old mu, next uses new.
REQ-035 Spurious dp_valid with inflight=0 -> err=1, FIFO count unchanged; err holds until rst.
REQ-036 rst low with 2 in flight and 1 buffered -> all outputs at reset values immediately; late dp_valid after release sets err.
